// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    localparam logic [1:0] IdleEnc  = 2'd0;
    localparam logic [1:0] ShiftEnc = 2'd1;
    localparam logic [1:0] DoneEnc  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = IdleEnc,
        StShift = ShiftEnc,
        StDone  = DoneEnc
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full adder, LSB first, registered carry,
// result and flags loaded once per operation.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             fa_sum, fa_cout;

    full_adder u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
                    opa_d   = a;
                    opb_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                opa_d            = opa_q >> 1;
                opb_d            = opb_q >> 1;
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = fa_sum;
                carry_d          = fa_cout;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    // carry_q is the carry into the MSB on this final bit.
                    state_d     = StDone;
                    result_d    = acc_d;
                    carry_out_d = fa_cout;
                    overflow_d  = carry_q ^ fa_cout;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign result      = result_q;
    assign carry_out   = carry_out_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign start_ready = (state_q == StIdle);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .result      (result),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after its acceptance edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        a = av;
        b = bv;
        sub = sv;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
    endtask

    // Waits (bounded) for done; cycles = edges after acceptance before done is seen.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cycles);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        #2;
        checks++;
        if ({result, carry_out, overflow, done, busy, start_ready} !== {8'h00, 5'b00001}) begin
            errors++;
            $display("FAIL reset_outputs: res=%h c=%b o=%b done=%b busy=%b rdy=%b, required 00 0 0 0 0 1",
                     result, carry_out, overflow, done, busy, start_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_latency();
        int cyc;
        start_op(8'd100, 8'd27, 1'b0);
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_busy: busy=%b rdy=%b, required 1 0", busy, start_ready);
        end
        wait_done(cyc);
        checks++;
        if (cyc != W) begin
            errors++;
            $display("FAIL done_latency: done seen %0d edges after accept, required %0d", cyc, W);
        end
        checks++;
        if ({result, carry_out, overflow} !== {8'd127, 2'b00}) begin
            errors++;
            $display("FAIL add_100_27: res=%0d c=%b o=%b, required 127 0 0", result, carry_out, overflow);
        end
        tick();
        checks++;
        if (done !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b rdy=%b busy=%b, required 0 1 0",
                     done, start_ready, busy);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] va [7] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h80, 8'h00, 8'h7F};
        logic [W-1:0] vb [7] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h80, 8'h00, 8'hFF};
        logic         vs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] er [7] = '{8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h80};
        logic         ec [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic         eo [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int cyc;
        for (int i = 0; i < 7; i++) begin
            start_op(va[i], vb[i], vs[i]);
            wait_done(cyc);
            checks++;
            if ({result, carry_out, overflow} !== {er[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL arith_%0d (%h %s %h): res=%h c=%b o=%b, required %h %b %b",
                         i, va[i], vs[i] ? "-" : "+", vb[i], result, carry_out, overflow,
                         er[i], ec[i], eo[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] prev_res;
        logic         prev_c;
        logic         prev_o;
        prev_res = result;
        prev_c = carry_out;
        prev_o = overflow;
        a = 8'h10;
        b = 8'h20;
        sub = 1'b0;
        start_valid = 1'b1;
        tick();
        // Samples after edges 0..8; operands churn but must not be picked up.
        for (int i = 0; i <= int'(W); i++) begin
            checks++;
            if (start_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready_%0d: rdy=%b, required 0", i, start_ready);
            end
            if (i < int'(W)) begin
                checks++;
                if ({result, carry_out, overflow} !== {prev_res, prev_c, prev_o}) begin
                    errors++;
                    $display("FAIL hold_during_shift_%0d: res=%h, required %h", i, result, prev_res);
                end
            end
            a = a + 8'h13;
            b = b ^ 8'h5A;
            sub = ~sub;
            tick();
        end
        // Now after edge 9: back in IDLE with the request still held high.
        checks++;
        if (start_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_edge9: rdy=%b done=%b, required 1 0", start_ready, done);
        end
        a = 8'd3;
        b = 8'd4;
        sub = 1'b0;
        tick();
        checks++;
        if (start_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_edge10: rdy=%b busy=%b, required 0 1", start_ready, busy);
        end
        for (int i = 0; i < int'(W); i++) begin
            checks++;
            if (result !== 8'h30 || done !== 1'b0) begin
                errors++;
                $display("FAIL sampled_result_%0d: res=%h done=%b, required 30 0", i, result, done);
            end
            a = ~a;
            b = b + 8'd1;
            tick();
        end
        start_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 8'd7) begin
            errors++;
            $display("FAIL b2b_second_result: done=%b res=%0d, required 1 7", done, result);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen_done;
        start_op(8'h80, 8'h01, 1'b1);
        wait_done(cyc);
        tick();
        start_op(8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({result, carry_out, overflow, done, busy, start_ready} !== {8'h00, 5'b00001}) begin
            errors++;
            $display("FAIL reset_mid: res=%h c=%b o=%b done=%b busy=%b rdy=%b, required 00 0 0 0 0 1",
                     result, carry_out, overflow, done, busy, start_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        checks++;
        if (seen_done != 0 || start_ready !== 1'b1 || result !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d rdy=%b res=%h, required 0 1 00",
                     seen_done, start_ready, result);
        end
        start_op(8'd3, 8'd4, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != W || {result, carry_out, overflow} !== {8'd7, 2'b00}) begin
            errors++;
            $display("FAIL after_reset_3_4: res=%0d c=%b o=%b lat=%0d, required 7 0 0 %0d",
                     result, carry_out, overflow, cyc, W);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_arith();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor built around the existing single-bit `full_adder` cell. It accepts two WIDTH-bit operands and an add/subtract select through a valid/ready handshake. It processes one bit per clock, LSB first, through one full-adder instance with a registered carry, then presents the registered result with carry and signed-overflow flags. It is the sequential, area-minimal counterpart to the ripple-carry datapath in the FA_RCA area.

## Interface
- `WIDTH`, default 8: operand/result width in bits. Legal range is WIDTH ≥ 1.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start_valid`, input, 1: request to begin an operation.
- `start_ready`, output, 1: block can accept a request. Equal to (state == IDLE).
- `a`, input, WIDTH: operand A, sampled only on the acceptance edge.
- `b`, input, WIDTH: operand B, sampled only on the acceptance edge.
- `sub`, input, 1: 0 gives A+B; 1 gives A−B. Sampled on the acceptance edge.
- `result`, output, WIDTH: registered sum or difference, modulo 2^WIDTH.
- `carry_out`, output, 1: final carry. For subtract this is the not-borrow (1 means A ≥ B unsigned).
- `overflow`, output, 1: two's-complement overflow, defined as (carry into MSB) XOR (carry out of MSB).
- `done`, output, 1: one-cycle pulse; result and flags are valid while it is high.
- `busy`, output, 1: state != IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- Acceptance edge: a rising edge where start_valid && start_ready. At this edge:
  - opA ← a, opB ← b ^ {WIDTH{sub}}.
  - carry ← sub; bit counter ← 0.
  - Next state is SHIFT.
- SHIFT, each edge:
  - `full_adder`(opA[0], opB[0], carry) is evaluated.
  - The sum bit shifts into the MSB of the accumulator; opA and opB shift right.
  - carry ← cout; counter increments.
  - carry_msb_in ← carry when counter == WIDTH−1.
  - When counter reaches WIDTH−1 on this edge, the next state is DONE, and result, carry_out and overflow are loaded from the accumulator and carry path.
- DONE: done = 1 for exactly one cycle, then the state returns to IDLE unconditionally. No acceptance is possible in DONE.
- result, carry_out and overflow hold their values from the DONE load until the next DONE load. They do not change during SHIFT.
- start_valid asserted outside IDLE is ignored; it is not queued. Changes on a, b or sub after the acceptance edge have no effect.
- WIDTH = 1: carry_msb_in equals the initial carry (sub), so overflow = sub XOR cout.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state IDLE.
  - result 0, carry_out 0, overflow 0, done 0, busy 0, start_ready 1.
  - Internal registers 0.
- Latency: with the acceptance edge counted as edge 0, the DONE load happens at edge WIDTH, and done is sampled high at edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. start_ready is high again in the cycle after done.
- Reset mid-operation: the operation is aborted, no done pulse occurs, and outputs return to their reset values. The first acceptance after release behaves normally.
- Counter width is $clog2(WIDTH+1). It never wraps within an operation.

## Structure
- Package `serial_addsub_pkg` holds the `state_t` enum (IDLE, SHIFT, DONE) and the state encoding constants.
- One sub-module: the existing `full_adder` (ports a, b, cin, sum, cout), instantiated once. No other submodules.
- All sequential logic is in `serial_addsub`.

## Test plan
All cases use WIDTH=8.
- ADD 100 + 27: result 127, carry_out 0, overflow 0. done is high at edge 9 after acceptance and for exactly one cycle.
- ADD 0xFF + 0x01: result 0x00, carry_out 1, overflow 0.
- ADD 0x7F + 0x01: result 0x80, carry_out 0, overflow 1.
- SUB 5 − 7: result 0xFE, carry_out 0, overflow 0.
- SUB 0x80 − 0x01: result 0x7F, carry_out 1, overflow 1.
- Busy handling:
  - Hold start_valid high and change a/b every cycle during SHIFT.
  - Required: start_ready stays 0, the result reflects the operands sampled at acceptance, and result stays stable through the next SHIFT.
  - Back-to-back requests are accepted exactly every 10 cycles.
- Reset mid-operation:
  - Assert rst_n low at SHIFT bit 4.
  - Required: all outputs return to reset values immediately, no done pulse, start_ready = 1.
  - A subsequent 3 + 4 operation yields 7.
